// File: rtl/receiver_buffer_register.sv
// receiver_buffer_register: oversampled 8N1 UART receiver with a one-byte holding buffer and error flags
module receiver_buffer_register #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       baud_tick,
    input  logic       rx_in,
    input  logic       signal_rd_en,
    output logic [7:0] data_out,
    output logic       signal_data_ready,
    output logic       signal_framing_err,
    output logic       signal_overrun_err
);
    localparam int CW = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            rdy_q, rdy_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic            s1_q, s2_q;
    logic            rx_s, ld, rd, keep, full, half;

    assign rx_s = s2_q;
    assign full = cnt_q == CW'(OVERSAMPLE - 1);
    assign half = cnt_q == CW'(OVERSAMPLE / 2 - 1);

    // receive sequencing: all counters and state move only on baud ticks
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ld      = 1'b0;
        if (baud_tick) begin
            cnt_d = cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!rx_s) state_d = START;
                end
                START: if (half) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
                DATA: if (full) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
                STOP: if (full) begin
                    cnt_d   = '0;
                    ld      = 1'b1;
                    state_d = rx_s ? IDLE : WAIT_HIGH;
                end
                default: begin
                    cnt_d = '0;
                    if (rx_s) state_d = IDLE;
                end
            endcase
        end
    end

    // holding buffer: a load into a full, unread buffer is dropped and flagged as overrun
    always_comb begin
        rd     = signal_rd_en && rdy_q;
        keep   = ld && rdy_q && !rd;
        data_d = (ld && !keep) ? shift_q : data_q;
        rdy_d  = ld || (rdy_q && !rd);
        ferr_d = keep ? ferr_q : ld ? !rx_s : (ferr_q && !rd);
        ovr_d  = keep ? 1'b1 : (ld || rd) ? 1'b0 : ovr_q;
    end

    // state registers with asynchronous reset; synchronizer resets to idle-high
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            s1_q    <= rx_in;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out           = data_q;
    assign signal_data_ready  = rdy_q;
    assign signal_framing_err = ferr_q;
    assign signal_overrun_err = ovr_q;
endmodule

// File: tb/tb_receiver_buffer_register.sv
// tb_receiver_buffer_register: directed self-checking bench for the UART receive buffer
module tb_receiver_buffer_register;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx_in = 1'b1;
    logic       signal_rd_en = 1'b0;
    logic [7:0] data_out;
    logic       signal_data_ready, signal_framing_err, signal_overrun_err;
    int         checks = 0;
    int         errors = 0;
    int         ph = 0;
    logic       r0, r1;

    receiver_buffer_register #(.OVERSAMPLE(16)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .baud_tick(baud_tick),
        .rx_in(rx_in),
        .signal_rd_en(signal_rd_en),
        .data_out(data_out),
        .signal_data_ready(signal_data_ready),
        .signal_framing_err(signal_framing_err),
        .signal_overrun_err(signal_overrun_err)
    );

    always #5 CLK = ~CLK;

    // one clock of stimulus; baud_tick every 4th clock so 16 ticks = 64 clocks per bit
    task automatic step();
        @(negedge CLK);
        baud_tick = (ph == 0);
        ph = (ph == 3) ? 0 : ph + 1;
    endtask

    // full 10-bit frame; optional read pulse lands on the posedge that follows step rd_at-1
    task automatic send_frame(input logic [7:0] d, input logic stop, input int rd_at, output logic rdy613, output logic rdy614);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        rdy613 = 1'b0;
        rdy614 = 1'b0;
        while (ph != 0) step();
        for (int c = 1; c <= 640; c++) begin
            rx_in = f[(c - 1) / 64];
            signal_rd_en = (c == rd_at);
            step();
            if (c == 613) rdy613 = signal_data_ready;
            if (c == 614) rdy614 = signal_data_ready;
        end
        signal_rd_en = 1'b0;
    endtask

    task automatic read_pulse();
        signal_rd_en = 1'b1;
        step();
        signal_rd_en = 1'b0;
        step();
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data_out); end
        checks++; if (signal_data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", signal_data_ready); end
        checks++; if (signal_framing_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", signal_framing_err); end
        checks++; if (signal_overrun_err !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", signal_overrun_err); end
        RST_N = 1'b1;
        repeat (20) step();
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b1, 0, r0, r1);
        checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL basic_ready_before_load got %b exp 0", r0); end
        checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL basic_ready_after_load got %b exp 1", r1); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", data_out); end
        checks++; if (signal_framing_err !== 1'b0) begin errors++; $display("FAIL basic_ferr got %b exp 0", signal_framing_err); end
        checks++; if (signal_overrun_err !== 1'b0) begin errors++; $display("FAIL basic_ovr got %b exp 0", signal_overrun_err); end
        read_pulse();
        checks++; if (signal_data_ready !== 1'b0) begin errors++; $display("FAIL basic_read_ready got %b exp 0", signal_data_ready); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL basic_read_data got %h exp a5", data_out); end
        read_pulse();
        checks++; if (signal_data_ready !== 1'b0) begin errors++; $display("FAIL empty_read_ready got %b exp 0", signal_data_ready); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL empty_read_data got %h exp a5", data_out); end
    endtask

    task automatic test_glitch();
        while (ph != 0) step();
        rx_in = 1'b0;
        repeat (16) step();
        rx_in = 1'b1;
        repeat (200) step();
        checks++; if (signal_data_ready !== 1'b0) begin errors++; $display("FAIL glitch_ready got %b exp 0", signal_data_ready); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL glitch_data got %h exp a5", data_out); end
        send_frame(8'h5A, 1'b1, 0, r0, r1);
        checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL glitch_next_data got %h exp 5a", data_out); end
        checks++; if (signal_data_ready !== 1'b1) begin errors++; $display("FAIL glitch_next_ready got %b exp 1", signal_data_ready); end
        read_pulse();
    endtask

    task automatic test_break();
        send_frame(8'h3C, 1'b0, 0, r0, r1);
        repeat (2560) step();
        checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL break_data got %h exp 3c", data_out); end
        checks++; if (signal_data_ready !== 1'b1) begin errors++; $display("FAIL break_ready got %b exp 1", signal_data_ready); end
        checks++; if (signal_framing_err !== 1'b1) begin errors++; $display("FAIL break_ferr got %b exp 1", signal_framing_err); end
        checks++; if (signal_overrun_err !== 1'b0) begin errors++; $display("FAIL break_ovr_low got %b exp 0", signal_overrun_err); end
        rx_in = 1'b1;
        repeat (200) step();
        checks++; if (signal_overrun_err !== 1'b0) begin errors++; $display("FAIL break_ovr_high got %b exp 0", signal_overrun_err); end
        read_pulse();
        checks++; if (signal_framing_err !== 1'b0) begin errors++; $display("FAIL break_read_ferr got %b exp 0", signal_framing_err); end
        checks++; if (signal_data_ready !== 1'b0) begin errors++; $display("FAIL break_read_ready got %b exp 0", signal_data_ready); end
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, 0, r0, r1);
        send_frame(8'h22, 1'b1, 0, r0, r1);
        checks++; if (data_out !== 8'h11) begin errors++; $display("FAIL ovr_data got %h exp 11", data_out); end
        checks++; if (signal_overrun_err !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", signal_overrun_err); end
        checks++; if (signal_data_ready !== 1'b1) begin errors++; $display("FAIL ovr_ready got %b exp 1", signal_data_ready); end
        read_pulse();
        checks++; if (signal_data_ready !== 1'b0) begin errors++; $display("FAIL ovr_read_ready got %b exp 0", signal_data_ready); end
        checks++; if (signal_overrun_err !== 1'b0) begin errors++; $display("FAIL ovr_read_flag got %b exp 0", signal_overrun_err); end
        checks++; if (signal_framing_err !== 1'b0) begin errors++; $display("FAIL ovr_read_ferr got %b exp 0", signal_framing_err); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b1, 0, r0, r1);
        send_frame(8'h22, 1'b1, 614, r0, r1);
        checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL b2b_ready_before got %b exp 1", r0); end
        checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_load got %b exp 1", r1); end
        checks++; if (data_out !== 8'h22) begin errors++; $display("FAIL b2b_data got %h exp 22", data_out); end
        checks++; if (signal_data_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", signal_data_ready); end
        checks++; if (signal_overrun_err !== 1'b0) begin errors++; $display("FAIL b2b_ovr got %b exp 0", signal_overrun_err); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] f;
        f = {1'b1, 8'hC3, 1'b0};
        while (ph != 0) step();
        for (int c = 1; c <= 352; c++) begin
            rx_in = f[(c - 1) / 64];
            step();
        end
        RST_N = 1'b0;
        #1;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_reset_data got %h exp 00", data_out); end
        checks++; if (signal_data_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got %b exp 0", signal_data_ready); end
        checks++; if (signal_overrun_err !== 1'b0) begin errors++; $display("FAIL mid_reset_ovr got %b exp 0", signal_overrun_err); end
        repeat (3) step();
        rx_in = 1'b1;
        RST_N = 1'b1;
        repeat (400) step();
        checks++; if (signal_data_ready !== 1'b0) begin errors++; $display("FAIL mid_partial_ready got %b exp 0", signal_data_ready); end
        send_frame(8'h7E, 1'b1, 0, r0, r1);
        checks++; if (data_out !== 8'h7E) begin errors++; $display("FAIL mid_next_data got %h exp 7e", data_out); end
        checks++; if (signal_data_ready !== 1'b1) begin errors++; $display("FAIL mid_next_ready got %b exp 1", signal_data_ready); end
        checks++; if (signal_framing_err !== 1'b0) begin errors++; $display("FAIL mid_next_ferr got %b exp 0", signal_framing_err); end
        checks++; if (signal_overrun_err !== 1'b0) begin errors++; $display("FAIL mid_next_ovr got %b exp 0", signal_overrun_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
